// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: shared debug-unit constants for the program loader.
package instruction_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [5:0]  HALT_OPCODE       = 6'b111111;
    localparam logic [31:0] HALT_WORD_DEFAULT = {HALT_OPCODE, 26'd0};

endpackage

// File: rtl/instruction_loader.sv
// instruction_loader: writes a UART byte stream big-endian into instruction memory,
// stopping on an aligned HALT word or when memory is full.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int                        MEMORY_WIDTH   = 8,
    parameter int                        MEMORY_DEPTH   = 256,
    parameter int                        NB_ADDR_DEPTH  = 8,
    parameter int                        NB_INSTRUCTION = 32,
    parameter logic [NB_INSTRUCTION-1:0] HALT_WORD      = HALT_WORD_DEFAULT
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_load_start,
    input  logic [MEMORY_WIDTH-1:0]  i_rx_data,
    input  logic                     i_rx_done,
    output logic                     o_write_enable,
    output logic [MEMORY_WIDTH-1:0]  o_write_data,
    output logic [NB_ADDR_DEPTH-1:0] o_write_addr,
    output logic                     o_busy,
    output logic                     o_load_done,
    output logic                     o_overflow,
    output logic [NB_ADDR_DEPTH:0]   o_byte_count
);

    localparam logic [NB_ADDR_DEPTH-1:0] LAST_ADDR = NB_ADDR_DEPTH'(MEMORY_DEPTH - 1);

    state_e                    state_q, state_d;
    logic [NB_ADDR_DEPTH-1:0]  addr_q, addr_d;
    logic [NB_ADDR_DEPTH:0]    count_q, count_d;
    logic [NB_INSTRUCTION-1:0] shift_q, shift_d;
    logic                      overflow_q, overflow_d;
    logic                      we_q, we_d;
    logic [MEMORY_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB_ADDR_DEPTH-1:0]  waddr_q, waddr_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      start_ok, accept, halt, last;
    logic [NB_INSTRUCTION-1:0] word;

    assign word     = {shift_q[NB_INSTRUCTION-MEMORY_WIDTH-1:0], i_rx_data};
    assign start_ok = i_load_start && (state_q != LOAD);
    assign accept   = i_rx_done && (state_q == LOAD);
    // Only a word ending on an aligned boundary can terminate the load.
    assign halt     = accept && (addr_q[1:0] == 2'd3) && (word == HALT_WORD);
    assign last     = accept && (addr_q == LAST_ADDR);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        shift_d    = shift_q;
        overflow_d = overflow_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        if (start_ok) begin
            state_d    = LOAD;
            addr_d     = '0;
            count_d    = '0;
            shift_d    = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            we_d       = 1'b1;
            wdata_d    = i_rx_data;
            waddr_d    = addr_q;
            shift_d    = word;
            count_d    = count_q + 1'b1;
            addr_d     = last ? addr_q : addr_q + 1'b1;
            state_d    = (halt || last) ? DONE : LOAD;
            overflow_d = last && !halt;
        end
        busy_d = (state_d == LOAD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_write_enable = we_q;
    assign o_write_data   = wdata_q;
    assign o_write_addr   = waddr_q;
    assign o_busy         = busy_q;
    assign o_load_done    = done_q;
    assign o_overflow     = overflow_q;
    assign o_byte_count   = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: scoreboard bench; stimulus queues expected writes, a monitor checks them.
module tb_instruction_loader;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_load_start = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic       o_write_enable;
    logic [7:0] o_write_data;
    logic [7:0] o_write_addr;
    logic       o_busy;
    logic       o_load_done;
    logic       o_overflow;
    logic [8:0] o_byte_count;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       done;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] mem [256];
    logic [7:0] misaligned [8] = '{8'h00, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    logic [7:0] prog [8]       = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};

    instruction_loader dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_load_start  (i_load_start),
        .i_rx_data     (i_rx_data),
        .i_rx_done     (i_rx_done),
        .o_write_enable(o_write_enable),
        .o_write_data  (o_write_data),
        .o_write_addr  (o_write_addr),
        .o_busy        (o_busy),
        .o_load_done   (o_load_done),
        .o_overflow    (o_overflow),
        .o_byte_count  (o_byte_count)
    );

    always #5 clk = ~clk;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (o_write_enable === 1'b1) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: addr %0d data %0h, expected no write", o_write_addr, o_write_data);
            end else begin
                mon_e = sb.pop_front();
                cmp("wr_addr", 32'(o_write_addr), 32'(mon_e.addr));
                cmp("wr_data", 32'(o_write_data), 32'(mon_e.data));
                cmp("done_at_write", 32'(o_load_done), 32'(mon_e.done));
                mem[o_write_addr] = o_write_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic wr, input logic [7:0] a, input logic d);
        i_rx_data = b;
        i_rx_done = 1'b1;
        if (wr) sb.push_back('{a, b, d});
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic start();
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
    endtask

    task automatic status(input string tag, input logic busy, input logic done, input logic ovf, input int cnt);
        cmp({tag, "_busy"}, 32'(o_busy), 32'(busy));
        cmp({tag, "_done"}, 32'(o_load_done), 32'(done));
        cmp({tag, "_overflow"}, 32'(o_overflow), 32'(ovf));
        cmp({tag, "_count"}, 32'(o_byte_count), 32'(cnt));
    endtask

    initial begin
        tick();
        tick();
        cmp("rst_we", 32'(o_write_enable), 0);
        cmp("rst_wdata", 32'(o_write_data), 0);
        cmp("rst_waddr", 32'(o_write_addr), 0);
        status("rst", 1'b0, 1'b0, 1'b0, 0);
        i_reset = 1'b0;
        tick();
        // Bytes in IDLE, then a start that coincides with a byte, are all dropped.
        send(8'hAA, 1'b0, 8'd0, 1'b0);
        i_load_start = 1'b1;
        send(8'hBB, 1'b0, 8'd0, 1'b0);
        i_load_start = 1'b0;
        status("start", 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) send(prog[i], 1'b1, 8'(i), i == 7);
        status("halt", 1'b0, 1'b1, 1'b0, 8);
        cmp("word0", {mem[0], mem[1], mem[2], mem[3]}, 32'h20010005);
        send(8'h55, 1'b0, 8'd0, 1'b0);
        i_load_start = 1'b1;
        send(8'h66, 1'b0, 8'd0, 1'b0);
        i_load_start = 1'b0;
        status("restart", 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) send(misaligned[i], 1'b1, 8'(i), 1'b0);
        status("misaligned", 1'b1, 1'b0, 1'b0, 8);
        for (int i = 8; i < 256; i++) send(8'h00, 1'b1, 8'(i), i == 255);
        status("full", 1'b0, 1'b1, 1'b1, 256);
        send(8'h77, 1'b0, 8'd0, 1'b0);
        tick();
        status("full_hold", 1'b0, 1'b1, 1'b1, 256);
        start();
        status("restart2", 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) send(8'h10 + 8'(i), 1'b1, 8'(i), 1'b0);
        start();
        send(8'h13, 1'b1, 8'd3, 1'b0);
        status("ignored_start", 1'b1, 1'b0, 1'b0, 4);
        send(8'h14, 1'b1, 8'd4, 1'b0);
        // Reset coincides with a sixth byte: its write must never appear.
        i_reset = 1'b1;
        send(8'h15, 1'b0, 8'd0, 1'b0);
        i_reset = 1'b0;
        cmp("midrst_we", 32'(o_write_enable), 0);
        cmp("midrst_waddr", 32'(o_write_addr), 0);
        status("midrst", 1'b0, 1'b0, 1'b0, 0);
        start();
        send(8'hFC, 1'b1, 8'd0, 1'b0);
        for (int i = 1; i < 4; i++) send(8'h00, 1'b1, 8'(i), i == 3);
        status("post_rst_halt", 1'b0, 1'b1, 1'b0, 4);
        start();
        for (int i = 0; i < 252; i++) send(8'h01, 1'b1, 8'(i), 1'b0);
        send(8'hFC, 1'b1, 8'd252, 1'b0);
        for (int i = 253; i < 256; i++) send(8'h00, 1'b1, 8'(i), i == 255);
        status("halt_at_end", 1'b0, 1'b1, 1'b0, 256);
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d writes outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Debug-unit-side program loader that sits directly upstream of the instruction memory's byte write port.
- Takes a byte stream from the UART receiver and writes it big-endian into instruction memory: first byte to address 0, which becomes instruction bits 31:24.
- Stops on an aligned HALT instruction word or when memory is full, then reports completion to the debug unit so it can start execution.

Parameters:
- MEMORY_WIDTH, 8, width of one memory entry and of one received byte
- MEMORY_DEPTH, 256, number of byte entries in instruction memory
- NB_ADDR_DEPTH, 8, width of the byte write address (log2 MEMORY_DEPTH)
- NB_INSTRUCTION, 32, instruction word width
- HALT_WORD, 32'hFC000000, instruction word that terminates a load

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_load_start  in  1  one-cycle pulse from the debug unit; begins a new load at address 0
- i_rx_data  in  MEMORY_WIDTH  received byte
- i_rx_done  in  1  one-cycle strobe; i_rx_data is valid this cycle
- o_write_enable  out  1  byte write strobe to instruction memory
- o_write_data  out  MEMORY_WIDTH  byte to write
- o_write_addr  out  NB_ADDR_DEPTH  byte address to write
- o_busy  out  1  high while in LOAD
- o_load_done  out  1  high while in DONE
- o_overflow  out  1  memory filled without a HALT word; valid in DONE
- o_byte_count  out  NB_ADDR_DEPTH+1  bytes written in the current or last load

Behaviour:
- Reset: all outputs 0; state IDLE; address counter 0; word shift register 0.
- All outputs are registered.
- States: IDLE, LOAD, DONE.
- IDLE: i_rx_done is ignored and no write occurs. i_load_start moves to LOAD and clears the address counter, o_byte_count, o_overflow and the shift register.
- LOAD, byte accept: an i_rx_done in cycle N is accepted. In cycle N+1, o_write_enable=1 for exactly one cycle, o_write_data=byte and o_write_addr=counter value at N. The counter and o_byte_count increment at the same edge.
- LOAD, word assembly: the shift register takes each byte as {reg[23:0], byte}.
- LOAD, HALT detection: when an accepted byte lands at an address with addr[1:0]==3 and {reg[23:0], byte}==HALT_WORD, the state becomes DONE at the same edge. The last HALT byte's write and o_load_done=1 coincide in cycle N+1.
- HALT matching is aligned only: a HALT_WORD pattern straddling a word boundary does not terminate the load.
- LOAD, memory full: accepting the byte at address MEMORY_DEPTH-1 without a HALT match moves to DONE with o_overflow=1. o_byte_count=MEMORY_DEPTH, which is why it is NB_ADDR_DEPTH+1 bits wide. The address never wraps.
- LOAD, other inputs: i_load_start is ignored, so a load cannot restart mid-stream. o_busy=1.
- DONE: o_load_done=1 and o_busy=0. i_rx_done is ignored. o_byte_count and o_overflow hold.
- DONE, restart: i_load_start returns to LOAD with counters cleared and o_load_done=0 from the next cycle.
- A HALT match on the last memory byte counts as HALT: o_overflow=0.
- Simultaneous i_load_start and i_rx_done in IDLE or DONE: the start is taken and the byte is dropped.
- Reset mid-LOAD: returns to IDLE the next cycle; any pending write strobe is cancelled (o_write_enable=0).

Decomposition:
- Shared package (debug-unit package):
  - state encoding constants IDLE=2'd0, LOAD=2'd1, DONE=2'd2
  - HALT opcode constant 6'b111111, with HALT_WORD default derived from it
- No sub-module. The word shift register and comparator stay inline; they are a few lines.

Test Plan:
- Reset, then 8 bytes 0x20,0x01,0x00,0x05,0xFC,0x00,0x00,0x00 after a start pulse:
  - writes go to addresses 0..7
  - o_load_done rises in the same cycle as the address-7 write
  - o_byte_count=8, o_overflow=0
  - a readback of word 0 from instruction memory is 0x20010005
- Bytes 0x00,0xFC,0x00,0x00,0x00,0x11,0x22,0x33 (misaligned HALT pattern) -> no termination at address 4; load continues, busy stays 1.
- 256 bytes of 0x00 -> DONE after the address-255 write; o_overflow=1; o_byte_count=256; no write to address 0 afterwards.
- i_rx_done in IDLE, in DONE, and in the same cycle as i_load_start -> no o_write_enable pulse.
- i_load_start in LOAD after 3 bytes -> ignored; the next byte is written to address 3.
- i_reset asserted during LOAD after 5 bytes -> IDLE next cycle with all outputs 0. A following start and bytes write from address 0.
